// File: rtl/mmio_bus.sv
// rtl/mmio_bus.sv - address decode for RAM, LED, free-running cycle counter and optional timer (MMIO_TIMER_EN)
`timescale 1ns/1ps
module mmio_bus #(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] IO_BASE   = 32'hFFFF0000,
    parameter int          LED_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      adr,
    input  logic [31:0]      writedata,
    input  logic             memwrite,
    output logic [31:0]      readdata,
    output logic             ram_we,
    input  logic [31:0]      ram_rd,
    output logic [LED_W-1:0] leds,
    output logic             timer_irq
);
    localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS * 4);
    localparam logic [29:0] IO_BASE_W = IO_BASE[31:2];

    logic             ram_sel;
    logic [29:0]      io_word;
    logic             io_led;
    logic             io_cycle;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      cycle_q, cycle_d;

    // Word offset into the I/O window; byte lanes adr[1:0] never take part in I/O decode.
    assign ram_sel  = adr < RAM_LIMIT;
    assign io_word  = adr[31:2] - IO_BASE_W;
    assign io_led   = !ram_sel && (io_word == 30'd0);
    assign io_cycle = !ram_sel && (io_word == 30'd1);
    assign ram_we   = memwrite & ram_sel;
    assign leds     = led_q;

    // LED takes the low writedata bits on a store; CYCLE free-runs and ignores stores.
    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        if (memwrite && io_led) begin
            led_d = writedata[LED_W-1:0];
        end
    end

    // LED and cycle counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            cycle_q <= '0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
        end
    end

`ifdef MMIO_TIMER_EN
    typedef enum logic [1:0] {T_IDLE, T_RUN, T_EXPIRE} tstate_e;

    tstate_e     state_q, state_d;
    logic [31:0] tcount_q, tcount_d;
    logic [31:0] treload_q, treload_d;
    logic        en_q, en_d;
    logic        ar_q, ar_d;
    logic        irq_q, irq_d;
    logic        io_tcount;
    logic        io_tctrl;
    logic        io_treload;

    assign io_tcount  = !ram_sel && (io_word == 30'd2);
    assign io_tctrl   = !ram_sel && (io_word == 30'd3);
    assign io_treload = !ram_sel && (io_word == 30'd4);
    assign timer_irq  = irq_q;

    // Timer next state: hardware count/expire first, then software writes override, then IRQ set wins over clear.
    always_comb begin
        tcount_d  = tcount_q;
        treload_d = treload_q;
        en_d      = en_q;
        ar_d      = ar_q;
        irq_d     = irq_q;
        case (state_q)
            T_RUN:    tcount_d = tcount_q - 32'd1;
            T_EXPIRE: begin
                if (ar_q) begin
                    tcount_d = treload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (memwrite && io_tcount) begin
            tcount_d = writedata;
        end
        if (memwrite && io_treload) begin
            treload_d = writedata;
        end
        if (memwrite && io_tctrl) begin
            en_d = writedata[0];
            ar_d = writedata[1];
            if (writedata[2]) begin
                irq_d = 1'b0;
            end
        end
        if (state_q == T_EXPIRE) begin
            irq_d = 1'b1;
        end
        if (!en_d) begin
            state_d = T_IDLE;
        end else if (tcount_d == 32'd0) begin
            state_d = T_EXPIRE;
        end else begin
            state_d = T_RUN;
        end
    end

    // Timer FSM and its registered control/status bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= T_IDLE;
            tcount_q  <= '0;
            treload_q <= '0;
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcount_q  <= tcount_d;
            treload_q <= treload_d;
            en_q      <= en_d;
            ar_q      <= ar_d;
            irq_q     <= irq_d;
        end
    end
`else
    logic unused_wdata;

    assign unused_wdata = ^writedata;
    assign timer_irq    = 1'b0;
`endif

    // Zero-latency read mux; anything not decoded reads as zero.
    always_comb begin
        readdata = '0;
        if (ram_sel) begin
            readdata = ram_rd;
        end else if (io_led) begin
            readdata = 32'(led_q);
        end else if (io_cycle) begin
            readdata = cycle_q;
        end
`ifdef MMIO_TIMER_EN
        else if (io_tcount) begin
            readdata = tcount_q;
        end else if (io_tctrl) begin
            readdata = {29'd0, irq_q, ar_q, en_q};
        end else if (io_treload) begin
            readdata = treload_q;
        end
`endif
    end
endmodule

// File: tb/tb_mmio_bus.sv
// tb/tb_mmio_bus.sv - directed bench for mmio_bus with a cycle-level reference model
`timescale 1ns/1ps
module tb_mmio_bus;
    localparam logic [31:0] IO   = 32'hFFFF0000;
    localparam logic [31:0] RAMB = 32'd256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] writedata = '0;
    logic        memwrite = 1'b0;
    logic [31:0] ram_rd = '0;
    logic [31:0] readdata;
    logic        ram_we;
    logic [7:0]  leds;
    logic        timer_irq;

    int   n_vec = 0;
    int   n_bad = 0;
    logic cyc_forced = 1'b0;

    logic [7:0]  m_led;
    logic [31:0] m_cycle;
`ifdef MMIO_TIMER_EN
    logic [31:0] m_tcount;
    logic [31:0] m_reload;
    logic        m_en;
    logic        m_ar;
    logic        m_irq;
`endif

    mmio_bus dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .ram_we    (ram_we),
        .ram_rd    (ram_rd),
        .leds      (leds),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    function automatic logic is_wr(input logic [31:0] off);
        return memwrite && (adr >= RAMB) && ({adr[31:2], 2'b00} == IO + off);
    endfunction

    // Reference model: register file behaviour written from the register map rules.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_led   <= '0;
            m_cycle <= '0;
`ifdef MMIO_TIMER_EN
            m_tcount <= '0;
            m_reload <= '0;
            m_en     <= 1'b0;
            m_ar     <= 1'b0;
            m_irq    <= 1'b0;
`endif
        end else begin
            if (is_wr(32'd0)) m_led <= writedata[7:0];
            m_cycle <= (cyc_forced ? 32'hFFFFFFFF : m_cycle) + 32'd1;
`ifdef MMIO_TIMER_EN
            if (is_wr(32'd8)) m_tcount <= writedata;
            else if (m_en) m_tcount <= (m_tcount != 0) ? m_tcount - 32'd1 : (m_ar ? m_reload : 32'd0);
            if (is_wr(32'd16)) m_reload <= writedata;
            if (is_wr(32'd12)) begin
                m_en <= writedata[0];
                m_ar <= writedata[1];
            end else if (m_en && m_tcount == 0 && !m_ar) begin
                m_en <= 1'b0;
            end
            if (m_en && m_tcount == 0) m_irq <= 1'b1;
            else if (is_wr(32'd12) && writedata[2]) m_irq <= 1'b0;
`endif
        end
    end

    function automatic logic [31:0] model_rd();
        logic [31:0] wa;
        wa = {adr[31:2], 2'b00};
        if (adr < RAMB) return ram_rd;
        if (wa == IO) return {24'd0, m_led};
        if (wa == IO + 32'd4) return m_cycle;
`ifdef MMIO_TIMER_EN
        if (wa == IO + 32'd8) return m_tcount;
        if (wa == IO + 32'd12) return {29'd0, m_irq, m_ar, m_en};
        if (wa == IO + 32'd16) return m_reload;
`endif
        return 32'd0;
    endfunction

    function automatic logic model_irq();
`ifdef MMIO_TIMER_EN
        return m_irq;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic compare_all();
        check("leds", {24'd0, leds}, {24'd0, m_led});
        check("timer_irq", {31'd0, timer_irq}, {31'd0, model_irq()});
        check("ram_we", {31'd0, ram_we}, {31'd0, memwrite && (adr < RAMB)});
        check("readdata", readdata, model_rd());
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        cyc();
        memwrite  = 1'b0;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        adr = a;
        #1;
        check(name, readdata, exp);
    endtask

    initial begin
        #1 reset = 1'b0;
        adr = IO;
        repeat (2) cyc();
        check("rst_leds", {24'd0, leds}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);

        adr   = IO + 32'd4;
        reset = 1'b1;
        repeat (10) cyc();
        check("cycle_10", readdata, 32'd10);

        force dut.cycle_q = 32'hFFFFFFFF;
        cyc_forced = 1'b1;
        #1;
        check("cycle_pre", readdata, 32'hFFFFFFFF);
        release dut.cycle_q;
        cyc();
        cyc_forced = 1'b0;
        check("cycle_wrap", readdata, 32'd0);

        wr(IO, 32'h1A5);
        check("led_pin", {24'd0, leds}, 32'hA5);
        peek("led_read", IO, 32'h000000A5);
        peek("led_unaligned", IO + 32'd2, 32'h000000A5);

        ram_rd    = 32'h12345678;
        writedata = 32'hDEADBEEF;
        memwrite  = 1'b1;
        peek("ram_rd_54", 32'h54, 32'h12345678);
        check("ram_we_54", {31'd0, ram_we}, 32'd1);
        peek("ram_rd_fc", 32'hFC, 32'h12345678);
        check("ram_we_fc", {31'd0, ram_we}, 32'd1);
        peek("unmapped_100", 32'h100, 32'd0);
        check("ram_we_100", {31'd0, ram_we}, 32'd0);
        peek("unmapped_1000", 32'h1000, 32'd0);
        check("ram_we_1000", {31'd0, ram_we}, 32'd0);
        cyc();
        memwrite = 1'b0;
        check("led_after_unmapped", {24'd0, leds}, 32'hA5);

`ifdef MMIO_TIMER_EN
        wr(IO + 32'd8, 32'd3);
        wr(IO + 32'd12, 32'd1);
        peek("tcount_3", IO + 32'd8, 32'd3);
        cyc(); check("tcount_2", readdata, 32'd2);
        cyc(); check("tcount_1", readdata, 32'd1);
        cyc(); check("tcount_0", readdata, 32'd0);
        check("irq_not_yet", {31'd0, timer_irq}, 32'd0);
        cyc(); check("irq_set", {31'd0, timer_irq}, 32'd1);
        check("tcount_hold", readdata, 32'd0);
        peek("tctrl_expired", IO + 32'd12, 32'h4);
        wr(IO + 32'd12, 32'h4);
        check("irq_w1c", {31'd0, timer_irq}, 32'd0);

        wr(IO + 32'd16, 32'd2);
        wr(IO + 32'd8, 32'd1);
        wr(IO + 32'd12, 32'h3);
        adr = IO + 32'd8;
        cyc(); check("ar_tcount_0", readdata, 32'd0);
        cyc(); check("ar_irq", {31'd0, timer_irq}, 32'd1);
        check("ar_reload", readdata, 32'd2);
        wr(IO + 32'd12, 32'h7);
        check("ar_irq_cleared", {31'd0, timer_irq}, 32'd0);
        peek("ar_tcount_1", IO + 32'd8, 32'd1);
        cyc(); check("ar_tcount_0b", readdata, 32'd0);
        wr(IO + 32'd12, 32'h7);
        check("irq_set_wins", {31'd0, timer_irq}, 32'd1);
        peek("ar_reload_2", IO + 32'd8, 32'd2);

        wr(IO + 32'd12, 32'h4);
        wr(IO + 32'd8, 32'd0);
        wr(IO + 32'd12, 32'h1);
        cyc(); check("en_at_zero_irq", {31'd0, timer_irq}, 32'd1);
        peek("en_at_zero_tctrl", IO + 32'd12, 32'h4);

        wr(IO + 32'd12, 32'h4);
        wr(IO + 32'd8, 32'd7);
        wr(IO + 32'd12, 32'h1);
        adr = IO + 32'd8;
        cyc(); cyc();
        check("mid_tcount_5", readdata, 32'd5);
        reset = 1'b0;
        #1;
        check("mid_rst_tcount", readdata, 32'd0);
        peek("mid_rst_tctrl", IO + 32'd12, 32'd0);
        check("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
`else
        wr(IO + 32'd8, 32'h1234);
        peek("notimer_tcount", IO + 32'd8, 32'd0);
        check("notimer_irq", {31'd0, timer_irq}, 32'd0);
        reset = 1'b0;
        #1;
`endif
        check("mid_rst_leds", {24'd0, leds}, 32'd0);
        peek("mid_rst_cycle", IO + 32'd4, 32'd0);
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        check("post_rst_cycle", readdata, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mmio_bus.md
MMIO_BUS -- requirements
Module: mmio_bus

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, which is the number of RAM words decoded from address 0.
REQ-002 SHALL have parameter IO_BASE, default 32'hFFFF0000, which is the base address of the I/O register window.
REQ-003 SHALL have parameter LED_W, default 8, which is the width of the LED output register.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous reset, active-low (0 = reset).
REQ-006 SHALL have port adr, input, 32 bits: byte address from the processor.
REQ-007 SHALL have port writedata, input, 32 bits: store data from the processor.
REQ-008 SHALL have port memwrite, input, 1 bit: store strobe from the processor.
REQ-009 SHALL have port readdata, output, 32 bits: load/fetch data to the processor.
REQ-010 SHALL have port ram_we, output, 1 bit: write enable to the RAM.
REQ-011 SHALL have port ram_rd, input, 32 bits: combinational read data from the RAM.
REQ-012 SHALL have port leds, output, LED_W bits: the LED register value.
REQ-013 SHALL have port timer_irq, output, 1 bit: the timer interrupt flag.

Function
REQ-014 SHALL decode addresses below RAM_WORDS*4 as RAM: ram_we = memwrite and readdata = ram_rd.
REQ-015 SHALL decode the I/O window at IO_BASE with word offsets: +0 LED (RW), +4 CYCLE (RO), +8 TCOUNT (RW), +C TCTRL (RW), +10 TRELOAD (RW).
REQ-016 SHALL, for any unmapped address, return readdata 0, ignore writes, and hold ram_we at 0.
REQ-017 SHALL make readdata combinational from adr with zero-cycle latency; register writes take effect at the rising edge where memwrite=1.
REQ-018 SHALL ignore adr[1:0] for I/O decode; sub-word access is not supported.
REQ-019 SHALL store writedata[LED_W-1:0] in LED on a write to +0; upper bits read as 0.
REQ-020 SHALL increment CYCLE by 1 every cycle, wrap from 32'hFFFFFFFF to 0, and ignore writes to it.
REQ-021 SHALL lay out TCTRL as: bit0 EN, bit1 AUTORELOAD, bit2 IRQ; other bits read 0.
REQ-022 SHALL treat TCTRL bit2 as write-1-to-clear, with the write value of EN and AUTORELOAD stored directly.
REQ-023 SHALL implement the timer FSM states IDLE (EN=0), RUN (EN=1, TCOUNT>0) and EXPIRE (EN=1, TCOUNT=0).
REQ-024 SHALL, in RUN, decrement TCOUNT by 1 per cycle.
REQ-025 SHALL, in the cycle where TCOUNT is 0 with EN=1, set IRQ at the next edge; if AUTORELOAD=1 it loads TRELOAD and stays running, else it clears EN and returns to IDLE with TCOUNT=0.
REQ-026 SHALL, when EN is written 1 while TCOUNT=0, take the EXPIRE path on the next cycle.
REQ-027 SHALL give a software write to TCOUNT priority over the same-cycle decrement or reload.
REQ-028 SHALL give a software write to TCTRL priority over the same-cycle hardware EN clear.
REQ-029 SHALL give hardware IRQ set priority over a same-cycle software IRQ clear.
REQ-030 SHALL drive timer_irq equal to the IRQ bit, registered with no combinational path from adr.

Reset
REQ-031 SHALL, while reset=0, force LED, CYCLE, TCOUNT, TRELOAD and TCTRL to 0 and the FSM to IDLE, regardless of clk.
REQ-032 SHALL hold leds=0 and timer_irq=0 during reset; ram_we and readdata remain combinational from the decode.
REQ-033 SHALL, on a reset asserted mid-count, abort the count with no IRQ; CYCLE restarts at 0 on the first edge after release.

Configuration
REQ-034 SHALL, with macro MMIO_TIMER_EN defined, include TCOUNT, TCTRL, TRELOAD, the FSM and timer_irq as specified.
REQ-035 SHALL, without MMIO_TIMER_EN, treat offsets +8/+C/+10 as unmapped (read 0, writes ignored), tie timer_irq to 0, and include no timer flops; LED and CYCLE are unaffected.

Verification
REQ-036 SHALL cover: write 0x1A5 to IO_BASE+0 -> leds=0xA5 after the edge; read of +0 returns 0x000000A5.
REQ-037 SHALL cover: memwrite at adr 0x54 -> ram_we=1; memwrite at adr 0x1000 -> ram_we=0, readdata=0, no register changes.
REQ-038 SHALL cover: release reset, read CYCLE 10 cycles later -> returns 10 (±0 per the edge counting in the bench); preload via forced state 0xFFFFFFFF -> wraps to 0.
REQ-039 SHALL cover: TCOUNT=3, TCTRL=0x1 -> TCOUNT reads 2,1,0; IRQ=1 one edge after 0; EN=0; TCOUNT stays 0.
REQ-040 SHALL cover: TRELOAD=2, TCOUNT=1, TCTRL=0x3 -> IRQ sets and TCOUNT reloads to 2 periodically; write TCTRL=0x7 in the same cycle as an expiry -> IRQ stays 1.
REQ-041 SHALL cover: reset=0 mid-count at TCOUNT=5 -> all registers 0, timer_irq=0; without MMIO_TIMER_EN, a write to +8 reads back 0 and timer_irq=0.
